bcd_to_bin_decoder: RTL and testbench

Sequential packed-BCD to binary converter for the 65C816 decimal-mode datapath. It accepts a `DIGITS`-digit packed BCD word and produces its binary value using reverse double-dabble: shift right one bit per cycle, then correct each digit. It is the decode-direction counterpart of the nibble BCD add/subtract logic, and is used wherever decimal-mode results must be interpreted as binary (debug/trace, IIGS firmware-visible conversions). It runs on a start/busy/done handshake and flags invalid BCD digits.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit_corr.sv | 12 +
 rtl/bcd_to_bin_decoder.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Digit-validity helper works on a zero-extended word of up to BCD_MAX_DIGITS digits.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
    localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0] BCD_CORR_VAL    = 4'd3;

    localparam int BCD_MAX_DIGITS = 16;
    localparam int BCD_MAX_W      = 4 * BCD_MAX_DIGITS;

    // Returns 1 when any of the low 'digits' nibbles of 'word' exceeds 9.
    function automatic logic bcd_has_invalid(input logic [BCD_MAX_W-1:0] word,
                                             input int digits);
        logic bad;
        logic [3:0] nib;
        bad = 1'b0;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            nib = word[i*4 +: 4];
            if ((i < digits) && (nib > BCD_DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit reverse double-dabble correction: digits of 8 or more lose 3.
// Purely combinational; the top instantiates one per BCD digit.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_CORR_THRESH) ? (digit_i - BCD_CORR_VAL) : digit_i;

endmodule

// File: rtl/bcd_to_bin_decoder.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// Start/busy/done handshake; invalid digits are reported immediately without converting.
module bcd_to_bin_decoder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [BIN_W-1:0]      BIN_OUT,
    output logic                  ERR
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WRK_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    bcd_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [WRK_W-1:0]   wrk_shifted;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BIN_W-1:0]   bin_shifted;
    logic [BCD_W-1:0]   bcd_corrected;
    logic               in_invalid;

    // The bcd LSB falls into the bin MSB as the concatenated register shifts right.
    assign wrk_shifted = {bcd_q, bin_q} >> 1;
    assign bcd_shifted = wrk_shifted[WRK_W-1:BIN_W];
    assign bin_shifted = wrk_shifted[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
            bcd_digit_corr u_corr (
                .digit_i (bcd_shifted[gi*4 +: 4]),
                .digit_o (bcd_corrected[gi*4 +: 4])
            );
        end
    endgenerate

    assign in_invalid = bcd_has_invalid(BCD_MAX_W'(BCD_IN), DIGITS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (in_invalid) begin
                        bin_out_d = '0;
                        err_d     = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        bcd_d   = BCD_IN;
                        bin_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_corrected;
                bin_d = bin_shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bin_out_d = bin_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign BUSY    = (state_q == SHIFT);
    assign DONE    = done_q;
    assign BIN_OUT = bin_out_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_decoder.sv
// Directed bench for bcd_to_bin_decoder (DIGITS=4, BIN_W=14) with hand-computed results.
module tb_bcd_to_bin_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [15:0] BCD_IN = 16'h0000;
    logic        BUSY;
    logic        DONE;
    logic [13:0] BIN_OUT;
    logic        ERR;

    int n_vec = 0;
    int n_err = 0;

    bcd_to_bin_decoder #(.DIGITS(4), .BIN_W(14)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .BCD_IN  (BCD_IN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .BIN_OUT (BIN_OUT),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives START for one sampling edge, then scrambles BCD_IN to prove it was captured.
    task automatic launch(input logic [15:0] v);
        START  = 1'b1;
        BCD_IN = v;
        step();
        START  = 1'b0;
        BCD_IN = 16'hFFFF;
    endtask

    // Polls for DONE with a cycle bound; lat counts edges since the accepting edge.
    task automatic wait_done(input int lat0, output int lat, output int busy_n);
        lat    = lat0;
        busy_n = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_n++;
            step();
            lat++;
        end
    endtask

    task automatic conv(input string tag, input logic [15:0] v, input logic [13:0] exp_bin);
        int lat, busy_n;
        launch(v);
        wait_done(0, lat, busy_n);
        chk({tag, "_latency"}, lat, 15);
        chk({tag, "_busy_cycles"}, busy_n, 14);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_bin"}, BIN_OUT, exp_bin);
        chk({tag, "_err"}, ERR, 0);
        chk({tag, "_busy_at_done"}, BUSY, 0);
    endtask

    initial begin
        int lat, busy_n;

        // Reset held for two cycles while START is asserted: RST must win.
        RST = 1'b1; START = 1'b1; BCD_IN = 16'h1234;
        step();
        step();
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_bin", BIN_OUT, 0);
        RST = 1'b0; START = 1'b0;
        step();
        chk("post_rst_busy", BUSY, 0);
        chk("post_rst_done", DONE, 0);

        conv("small_12", 16'h0012, 14'd12);
        step();
        chk("small_12_pulse", DONE, 0);

        conv("max_9999", 16'h9999, 14'h270F);
        step();
        chk("max_9999_pulse", DONE, 0);

        conv("zero", 16'h0000, 14'd0);
        step();
        chk("zero_pulse", DONE, 0);

        // Invalid digit: immediate error, no conversion.
        launch(16'h12A4);
        chk("inv_done", DONE, 1);
        chk("inv_err", ERR, 1);
        chk("inv_bin", BIN_OUT, 0);
        chk("inv_busy", BUSY, 0);
        step();
        chk("inv_pulse", DONE, 0);
        chk("inv_busy2", BUSY, 0);
        chk("inv_err_held", ERR, 1);

        conv("after_inv_42", 16'h0042, 14'd42);
        step();

        // START pulsed 3 cycles into a conversion must be ignored.
        launch(16'h0777);
        step();
        step();
        START = 1'b1; BCD_IN = 16'h0001;
        step();
        START = 1'b0;
        wait_done(3, lat, busy_n);
        chk("ign_latency", lat, 15);
        chk("ign_bin", BIN_OUT, 14'd777);
        chk("ign_err", ERR, 0);

        // START during the DONE cycle is accepted.
        conv("b2b_100", 16'h0100, 14'd100);

        // Reset after the 5th shift aborts the conversion.
        step();
        launch(16'h4321);
        for (int i = 0; i < 5; i++) step();
        chk("mid_busy_pre", BUSY, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_err", ERR, 0);
        chk("mid_rst_bin", BIN_OUT, 0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (DONE || BUSY) lat++;
            step();
        end
        chk("mid_rst_quiet", lat, 0);

        conv("after_rst_500", 16'h0500, 14'h01F4);
        step();
        chk("after_rst_pulse", DONE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
